div_lane_scheduler: RTL

- Dispatches per-pixel perspective division jobs (num_x, num_y, denom, destination address tag) round-robin across NUM_LANES external signed divider pairs.
- Retires results strictly in issue order, with an out-of-bounds flag, to the VGA-buffer writer.
- Sits between the incremental numerator/denominator generator and the divider instances. Overlapping the ~80-cycle divisions raises pixel throughput by roughly NUM_LANES.

---
 rtl/div_lane_scheduler.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/div_lane_scheduler.sv
// div_lane_scheduler: round-robin dispatch of perspective-divide jobs to
// NUM_LANES external divider pairs, in-order retire with out-of-bounds flag.
//
// Ports:
//   clk, reset              clock, async active-high reset
//   job_*                   job offer (valid/ready), operands and tag
//   lane_start/num/denom    per-lane divider launch (lane i at [i*WIDTH +: WIDTH])
//   lane_done/quot_x/quot_y per-lane divider results
//   res_*                   in-order result stream (valid/ready)
//   lanes_busy              lane i not idle
module div_lane_scheduler #(
  parameter int NUM_LANES = 4,
  parameter int WIDTH     = 79,
  parameter int TAG_W     = 17,
  parameter int XMAX      = 639,
  parameter int YMAX      = 479
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       job_valid,
  output logic                       job_ready,
  input  logic [WIDTH-1:0]           job_num_x,
  input  logic [WIDTH-1:0]           job_num_y,
  input  logic [WIDTH-1:0]           job_denom,
  input  logic [TAG_W-1:0]           job_tag,
  output logic [NUM_LANES-1:0]       lane_start,
  output logic [NUM_LANES*WIDTH-1:0] lane_num_x,
  output logic [NUM_LANES*WIDTH-1:0] lane_num_y,
  output logic [NUM_LANES*WIDTH-1:0] lane_denom,
  input  logic [NUM_LANES-1:0]       lane_done,
  input  logic [NUM_LANES*WIDTH-1:0] lane_quot_x,
  input  logic [NUM_LANES*WIDTH-1:0] lane_quot_y,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [WIDTH-1:0]           res_x,
  output logic [WIDTH-1:0]           res_y,
  output logic [TAG_W-1:0]           res_tag,
  output logic                       res_oob,
  output logic [NUM_LANES-1:0]       lanes_busy
);

  localparam int PW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  localparam logic signed [WIDTH-1:0] XLIM = WIDTH'(XMAX);
  localparam logic signed [WIDTH-1:0] YLIM = WIDTH'(YMAX);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_HOLD
  } lane_st_e;

  lane_st_e         st    [NUM_LANES];
  logic [WIDTH-1:0] q_x   [NUM_LANES];
  logic [WIDTH-1:0] q_y   [NUM_LANES];
  logic [TAG_W-1:0] tag_r [NUM_LANES];
  logic             oob_r [NUM_LANES];

  logic [PW-1:0] issue_ptr;
  logic [PW-1:0] retire_ptr;
  logic          accept;
  logic          retire;

  // Ready comes from registered lane state only, so a lane freed by
  // a retire this cycle is offered no earlier than the next cycle.
  assign job_ready = !reset && (st[issue_ptr] == S_IDLE);
  assign accept    = job_valid && job_ready;

  assign res_valid = (st[retire_ptr] == S_HOLD);
  assign retire    = res_valid && res_ready;
  assign res_x     = q_x[retire_ptr];
  assign res_y     = q_y[retire_ptr];
  assign res_tag   = tag_r[retire_ptr];
  assign res_oob   = oob_r[retire_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      issue_ptr  <= '0;
      retire_ptr <= '0;
    end else begin
      if (accept) issue_ptr <= issue_ptr + PW'(1);
      if (retire) retire_ptr <= retire_ptr + PW'(1);
    end
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    lane_st_e                st_q;
    logic [1:0]              guard_q;
    logic [WIDTH-1:0]        op_x_q;
    logic [WIDTH-1:0]        op_y_q;
    logic [WIDTH-1:0]        op_d_q;
    logic [WIDTH-1:0]        qx_q;
    logic [WIDTH-1:0]        qy_q;
    logic [TAG_W-1:0]        tag_q;
    logic                    oob_q;
    logic signed [WIDTH-1:0] dqx;
    logic signed [WIDTH-1:0] dqy;
    logic                    cap_oob;
    logic                    sel_acc;
    logic                    sel_ret;

    assign dqx = lane_quot_x[i*WIDTH +: WIDTH];
    assign dqy = lane_quot_y[i*WIDTH +: WIDTH];

    assign cap_oob = (dqx < 0) || (dqx > XLIM) ||
                     (dqy < 0) || (dqy > YLIM);

    assign sel_acc = accept && (issue_ptr == PW'(i));
    assign sel_ret = retire && (retire_ptr == PW'(i));

    assign st[i]    = st_q;
    assign q_x[i]   = qx_q;
    assign q_y[i]   = qy_q;
    assign tag_r[i] = tag_q;
    assign oob_r[i] = oob_q;

    assign lane_start[i] = (st_q == S_LAUNCH) && (op_d_q != '0);
    assign lanes_busy[i] = (st_q != S_IDLE);

    assign lane_num_x[i*WIDTH +: WIDTH] = op_x_q;
    assign lane_num_y[i*WIDTH +: WIDTH] = op_y_q;
    assign lane_denom[i*WIDTH +: WIDTH] = op_d_q;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        st_q    <= S_IDLE;
        guard_q <= '0;
        op_x_q  <= '0;
        op_y_q  <= '0;
        op_d_q  <= '0;
        qx_q    <= '0;
        qy_q    <= '0;
        tag_q   <= '0;
        oob_q   <= 1'b0;
      end else begin
        unique case (st_q)
          S_IDLE: begin
            if (sel_acc) begin
              op_x_q <= job_num_x;
              op_y_q <= job_num_y;
              op_d_q <= job_denom;
              tag_q  <= job_tag;
              st_q   <= S_LAUNCH;
            end
          end
          S_LAUNCH: begin
            guard_q <= '0;
            if (op_d_q == '0) begin
              qx_q  <= '0;
              qy_q  <= '0;
              oob_q <= 1'b1;
              st_q  <= S_HOLD;
            end else begin
              st_q <= S_WAIT;
            end
          end
          S_WAIT: begin
            // The divider's done level may still be high from the
            // previous operation for a couple of cycles after start.
            if (guard_q != 2'd2) begin
              guard_q <= guard_q + 2'd1;
            end else if (lane_done[i]) begin
              qx_q  <= dqx;
              qy_q  <= dqy;
              oob_q <= cap_oob;
              st_q  <= S_HOLD;
            end
          end
          S_HOLD: begin
            if (sel_ret) st_q <= S_IDLE;
          end
          default: st_q <= S_IDLE;
        endcase
      end
    end
  end

endmodule
